// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader: serialises bytes MSB-first onto ccff_head and
// releases fabric isolation once CHAIN_LEN bits are in. Define CCFF_LOADER_CRC_EN for CRC-16 check.
module ccff_loader #(
  parameter int CHAIN_LEN = 4096,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       prog_resetb,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       ccff_clk_en,
  output logic       isol_n,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef CCFF_LOADER_CRC_EN
    S_CRC,
`endif
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       sr_q;
  logic [3:0]       occ_q;
  logic             head_q, en_q, isol_q, busy_q, done_q;
  logic             rdy_c, take_c, shift_c;

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q;
  logic        crc_n_q, err_q;

  assign crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sr_q[7]) ? 16'h1021 : 16'h0000);
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Refill is allowed while the last bit of the current byte is shifting,
  // unless that shift fills the chain.
  always_comb begin
    rdy_c = 1'b0;
    case (state_q)
      S_LOAD:  rdy_c = (cnt_q != LEN) &&
                       ((occ_q == 4'd0) || ((occ_q == 4'd1) && (cnt_q < LEN_M1)));
`ifdef CCFF_LOADER_CRC_EN
      S_CRC:   rdy_c = 1'b1;
`endif
      default: rdy_c = 1'b0;
    endcase
  end

  assign take_c  = byte_valid & rdy_c;
  assign shift_c = (state_q == S_LOAD) && (occ_q != 4'd0) && (cnt_q != LEN);

  always_ff @(posedge prog_clk) begin
    if (!prog_resetb) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      occ_q    <= '0;
      head_q   <= 1'b0;
      en_q     <= 1'b0;
      isol_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
      crc_q    <= 16'hFFFF;
      crc_hi_q <= '0;
      crc_n_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          en_q <= shift_c;
          if (shift_c) head_q <= sr_q[7];
          if (cnt_q == LEN) begin
            occ_q <= '0;
`ifdef CCFF_LOADER_CRC_EN
            state_q <= S_CRC;
`else
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            isol_q  <= 1'b1;
`endif
          end else begin
            if (take_c) begin
              sr_q  <= byte_data;
              occ_q <= 4'd8;
            end else if (shift_c) begin
              sr_q  <= {sr_q[6:0], 1'b0};
              occ_q <= occ_q - 4'd1;
            end
            if (shift_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
`ifdef CCFF_LOADER_CRC_EN
              crc_q <= crc_d;
`endif
              // Final chain bit: drop whatever is left of the current byte.
              if (cnt_q == LEN_M1) occ_q <= '0;
            end
          end
        end
`ifdef CCFF_LOADER_CRC_EN
        S_CRC: begin
          en_q <= 1'b0;
          if (take_c) begin
            if (!crc_n_q) begin
              crc_hi_q <= byte_data;
              crc_n_q  <= 1'b1;
            end else begin
              busy_q <= 1'b0;
              if ({crc_hi_q, byte_data} == crc_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                isol_q  <= 1'b1;
              end else begin
                state_q <= S_FAIL;
                err_q   <= 1'b1;
              end
            end
          end
        end
`endif
        default: begin
          en_q <= 1'b0;
          if (start) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            occ_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            isol_q  <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
            crc_q   <= 16'hFFFF;
            crc_n_q <= 1'b0;
            err_q   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign byte_ready  = rdy_c;
  assign ccff_head   = head_q;
  assign ccff_clk_en = en_q;
  assign isol_n      = isol_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: unit 0 has a 20-bit chain, unit 1 a 16-bit chain (CRC when enabled).
module tb_ccff_loader;
  logic       clk = 1'b0;
  logic       rstb;
  logic [1:0] st, vld, rdy, head, en, isol, busy, done, err;
  logic [7:0] dat [2];

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(20)) u_a (
    .prog_clk(clk), .prog_resetb(rstb), .start(st[0]), .byte_data(dat[0]),
    .byte_valid(vld[0]), .byte_ready(rdy[0]), .ccff_head(head[0]), .ccff_clk_en(en[0]),
    .isol_n(isol[0]), .busy(busy[0]), .done(done[0]), .error(err[0]));

  ccff_loader #(.CHAIN_LEN(16)) u_b (
    .prog_clk(clk), .prog_resetb(rstb), .start(st[1]), .byte_data(dat[1]),
    .byte_valid(vld[1]), .byte_ready(rdy[1]), .ccff_head(head[1]), .ccff_clk_en(en[1]),
    .isol_n(isol[1]), .busy(busy[1]), .done(done[1]), .error(err[1]));

  int n_chk = 0, n_err = 0;
  logic [63:0] cap [2] = '{default: '0};
  int en_cnt [2] = '{default: 0};
  int bi_cnt [2] = '{default: 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chain-side capture: bits shifted, enabled cycles, busy cycles without a shift.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (en[u]) begin
        cap[u] = {cap[u][62:0], head[u]};
        en_cnt[u]++;
      end else if (busy[u]) begin
        bi_cnt[u]++;
      end
    end
  end

  task automatic pulse_start(input int u);
    st[u] = 1'b1;
    @(posedge clk); #1;
    st[u] = 1'b0;
  endtask

  task automatic put(input int u, input logic [7:0] b);
    dat[u] = b;
    vld[u] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy[u]) begin
        @(posedge clk); #1;
        vld[u] = 1'b0;
        return;
      end
    end
    vld[u] = 1'b0;
    chk("put_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_end(input int u, input string tag, input bit lag_chk);
    logic pe;
    pe = en[u];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy[u]) begin
        if (lag_chk) chk({tag, "_done_lag"}, {30'd0, pe, en[u]}, 32'b10);
        return;
      end
      pe = en[u];
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

`ifdef CCFF_LOADER_CRC_EN
  function automatic logic [15:0] crc16(input logic [15:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 15; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, i0;
    logic [15:0] crc;
    rstb = 1'b0; st = '0; vld = '0; dat[0] = '0; dat[1] = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {18'd0, rdy, head, en, isol, busy, done, err}, 32'd0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Continuous stream, 20-bit chain
    e0 = en_cnt[0]; i0 = bi_cnt[0];
    pulse_start(0);
    chk("t1_start", {29'd0, busy[0], done[0], isol[0]}, 32'b100);
    put(0, 8'hA5); put(0, 8'h3C); put(0, 8'hF0);
    wait_end(0, "t1", 1'b1);
    chk("t1_bits", cap[0][19:0], 32'hA53CF);
    chk("t1_en_cycles", en_cnt[0] - e0, 32'd20);
    chk("t1_fill", bi_cnt[0] - i0, 32'd2);
    chk("t1_end", {27'd0, done[0], isol[0], busy[0], en[0], rdy[0]}, 32'b11000);

    // 5-cycle underrun before the third byte
    e0 = en_cnt[0]; i0 = bi_cnt[0];
    pulse_start(0);
    put(0, 8'hA5); put(0, 8'h3C);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    repeat (5) @(posedge clk); #1;
    put(0, 8'hF0);
    wait_end(0, "t2", 1'b1);
    chk("t2_bits", cap[0][19:0], 32'hA53CF);
    chk("t2_en_cycles", en_cnt[0] - e0, 32'd20);
    chk("t2_stall", bi_cnt[0] - i0, 32'd7);

    // start held high mid-load is ignored
    e0 = en_cnt[0];
    pulse_start(0);
    put(0, 8'hA5);
    st[0] = 1'b1;
    put(0, 8'h3C);
    st[0] = 1'b0;
    put(0, 8'hF0);
    wait_end(0, "t3", 1'b1);
    chk("t3_bits", cap[0][19:0], 32'hA53CF);
    chk("t3_en_cycles", en_cnt[0] - e0, 32'd20);

    // Reset after 9 shifts, then a fresh load from bit 0
    e0 = en_cnt[0];
    pulse_start(0);
    put(0, 8'hA5); put(0, 8'h3C);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (en_cnt[0] - e0 >= 9) break;
    end
    chk("t4_shifts_before_rst", en_cnt[0] - e0, 32'd9);
    rstb = 1'b0;
    @(posedge clk); #1;
    chk("t4_rst_outputs", {25'd0, rdy[0], head[0], en[0], isol[0], busy[0], done[0], err[0]}, 32'd0);
    rstb = 1'b1;
    @(posedge clk); #1;
    e0 = en_cnt[0];
    pulse_start(0);
    put(0, 8'h3C); put(0, 8'hA5); put(0, 8'h0F);
    wait_end(0, "t4", 1'b1);
    chk("t4_bits", cap[0][19:0], 32'h3CA50);
    chk("t4_en_cycles", en_cnt[0] - e0, 32'd20);

    // Reload from DONE with a new pattern
    chk("t5_pre", {30'd0, done[0], isol[0]}, 32'b11);
    pulse_start(0);
    chk("t5_start", {29'd0, busy[0], done[0], isol[0]}, 32'b100);
    put(0, 8'h5A); put(0, 8'hC3); put(0, 8'h70);
    wait_end(0, "t5", 1'b1);
    chk("t5_bits", cap[0][19:0], 32'h5AC37);
    chk("t5_done", {30'd0, done[0], isol[0]}, 32'b11);

    // 16-bit chain, byte-aligned length
    e0 = en_cnt[1];
    pulse_start(1);
    put(1, 8'h12); put(1, 8'h34);
`ifdef CCFF_LOADER_CRC_EN
    crc = crc16(16'h1234);
    put(1, crc[15:8]); put(1, crc[7:0]);
    wait_end(1, "t6", 1'b0);
    chk("t6_bits", cap[1][15:0], 32'h1234);
    chk("t6_en_cycles", en_cnt[1] - e0, 32'd16);
    chk("t6_crc_ok", {29'd0, done[1], isol[1], err[1]}, 32'b110);
    pulse_start(1);
    put(1, 8'h12); put(1, 8'h34);
    put(1, crc[15:8]); put(1, crc[7:0] ^ 8'h01);
    wait_end(1, "t7", 1'b0);
    chk("t7_crc_bad", {28'd0, done[1], isol[1], err[1], busy[1]}, 32'b0010);
`else
    crc = 16'h0;
    wait_end(1, "t6", 1'b1);
    chk("t6_bits", cap[1][15:0], 32'h1234 ^ {16'd0, crc});
    chk("t6_en_cycles", en_cnt[1] - e0, 32'd16);
    chk("t6_done", {29'd0, done[1], isol[1], err[1]}, 32'b110);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
